fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Purpose: shares one store-FIFO write port among NREQ requesters, round-robin with locked bursts.
// Latency: grant is combinational; the accepted beat appears on the FIFO write port one cycle later.
// Backpressure: full, or nearly-full with a write in flight, blocks all grants and freezes arbitration.
module fifo_wr_arbiter #(
    parameter  int NREQ       = 4,
    parameter  int DATA_WIDTH = 32,
    parameter  int MAX_BURST  = 8,
    localparam int IDW        = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_i,
    input  logic [NREQ-1:0]            lock_i,
    input  logic [NREQ*DATA_WIDTH-1:0] data_i,
    output logic [NREQ-1:0]            gnt_o,
    output logic                       fifo_wr_en_o,
    output logic [IDW+DATA_WIDTH-1:0]  fifo_wr_data_o,
    input  logic                       fifo_full_i,
    input  logic                       fifo_nearly_full_i,
    output logic [IDW-1:0]             owner_o,
    output logic                       locked_o
);

    typedef enum logic {
        ARB   = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam bit          BURST_EN  = (MAX_BURST > 1);
    localparam logic [8:0]  MAX_BURST9 = 9'(MAX_BURST);
    localparam logic [IDW-1:0] LAST_RST = IDW'(NREQ - 1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic [IDW-1:0]        r_last;
    logic [IDW-1:0]        w_last_nxt;
    logic [IDW-1:0]        r_owner;
    logic [IDW-1:0]        w_owner_nxt;
    logic [7:0]            r_cnt;
    logic [7:0]            w_cnt_nxt;
    logic [8:0]            w_cnt_inc;
    logic                  w_ok;
    logic                  w_accept;
    logic [IDW-1:0]        w_rr_win;
    logic [IDW-1:0]        w_sel;
    logic [DATA_WIDTH-1:0] w_payload;

    // First requester strictly after 'last', wrapping modulo NREQ.
    function automatic logic [IDW-1:0] f_rr_pick(input logic [NREQ-1:0] req,
                                                 input logic [IDW-1:0]  last);
        logic [IDW-1:0] pick;
        logic           found;
        int unsigned    idx;
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(last) + i) % NREQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                pick  = idx[IDW-1:0];
            end
        end
        return pick;
    endfunction

    assign w_ok     = !fifo_full_i && !(fifo_nearly_full_i && fifo_wr_en_o);
    assign w_rr_win = f_rr_pick(req_i, r_last);

    always_comb begin
        w_state_nxt = r_state;
        w_last_nxt  = r_last;
        w_owner_nxt = r_owner;
        w_cnt_nxt   = r_cnt;
        w_sel       = r_owner;
        w_accept    = 1'b0;
        w_cnt_inc   = {1'b0, r_cnt} + 9'd1;
        case (r_state)
            ARB: begin
                w_sel    = w_rr_win;
                w_accept = w_ok && (|req_i);
                if (w_accept) begin
                    if (lock_i[w_rr_win] && BURST_EN) begin
                        w_state_nxt = BURST;
                        w_owner_nxt = w_rr_win;
                        w_cnt_nxt   = 8'd1;
                    end else begin
                        w_last_nxt = w_rr_win;
                    end
                end
            end
            BURST: begin
                w_accept = w_ok && req_i[r_owner];
                if (w_accept) begin
                    w_cnt_nxt = w_cnt_inc[7:0];
                    if (!lock_i[r_owner] || (w_cnt_inc == MAX_BURST9)) begin
                        w_state_nxt = ARB;
                        w_last_nxt  = r_owner;
                    end
                end else if (w_ok && !req_i[r_owner] && !lock_i[r_owner]) begin
                    // Owner walked away without finishing: release the port.
                    w_state_nxt = ARB;
                    w_last_nxt  = r_owner;
                end
            end
            default: w_state_nxt = ARB;
        endcase
    end

    always_comb begin
        w_payload = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_sel == IDW'(k)) begin
                w_payload = data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        gnt_o = '0;
        if (w_accept && !rst) begin
            gnt_o[w_sel] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ARB;
            r_last         <= LAST_RST;
            r_owner        <= '0;
            r_cnt          <= '0;
            fifo_wr_en_o   <= 1'b0;
            fifo_wr_data_o <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_last       <= w_last_nxt;
            r_owner      <= w_owner_nxt;
            r_cnt        <= w_cnt_nxt;
            fifo_wr_en_o <= w_accept;
            if (w_accept) begin
                fifo_wr_data_o <= {w_sel, w_payload};
            end
        end
    end

    assign locked_o = (r_state == BURST) && !rst;
    assign owner_o  = locked_o ? r_owner : '0;

endmodule
